// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low glyph constants {g,f,e,d,c,b,a},
// capture FSM states and the decoded nibble width.
package sseg_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [6:0] SSEG_0     = 7'b1000000;
  localparam logic [6:0] SSEG_1     = 7'b1111001;
  localparam logic [6:0] SSEG_2     = 7'b0100100;
  localparam logic [6:0] SSEG_3     = 7'b0110000;
  localparam logic [6:0] SSEG_4     = 7'b0011001;
  localparam logic [6:0] SSEG_5     = 7'b0010010;
  localparam logic [6:0] SSEG_6     = 7'b0000010;
  localparam logic [6:0] SSEG_7     = 7'b1111000;
  localparam logic [6:0] SSEG_8     = 7'b0000000;
  localparam logic [6:0] SSEG_9     = 7'b0010000;
  localparam logic [6:0] SSEG_A     = 7'b0001000;
  localparam logic [6:0] SSEG_B     = 7'b0000011;
  localparam logic [6:0] SSEG_C     = 7'b1000110;
  localparam logic [6:0] SSEG_D     = 7'b0100001;
  localparam logic [6:0] SSEG_E     = 7'b0000110;
  localparam logic [6:0] SSEG_F     = 7'b0001110;
  localparam logic [6:0] SSEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] nibble;
    logic                dp;
    logic                blank;
    logic                err;
  } glyph_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational active-low segment pattern -> {nibble, dp, blank, err}.
// Define SSEG_SCAN_CAPTURE_HEX_EN to accept the A-F glyphs as legal digits.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [7:0] sseg,
  output glyph_t     glyph
);

  always_comb begin
    glyph       = '0;
    glyph.dp    = ~sseg[7];
    case (sseg[6:0])
      SSEG_0:     glyph.nibble = 4'h0;
      SSEG_1:     glyph.nibble = 4'h1;
      SSEG_2:     glyph.nibble = 4'h2;
      SSEG_3:     glyph.nibble = 4'h3;
      SSEG_4:     glyph.nibble = 4'h4;
      SSEG_5:     glyph.nibble = 4'h5;
      SSEG_6:     glyph.nibble = 4'h6;
      SSEG_7:     glyph.nibble = 4'h7;
      SSEG_8:     glyph.nibble = 4'h8;
      SSEG_9:     glyph.nibble = 4'h9;
      SSEG_BLANK: glyph.blank  = 1'b1;
`ifdef SSEG_SCAN_CAPTURE_HEX_EN
      SSEG_A:     glyph.nibble = 4'hA;
      SSEG_B:     glyph.nibble = 4'hB;
      SSEG_C:     glyph.nibble = 4'hC;
      SSEG_D:     glyph.nibble = 4'hD;
      SSEG_E:     glyph.nibble = 4'hE;
      SSEG_F:     glyph.nibble = 4'hF;
`else
      SSEG_A, SSEG_B, SSEG_C, SSEG_D, SSEG_E, SSEG_F: glyph.err = 1'b1;
`endif
      default:    glyph.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Captures a multiplexed seven-segment scan into an atomically updated frame.
// Optional hex glyph decoding via SSEG_SCAN_CAPTURE_HEX_EN (see sseg_glyph_decode).
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_DIGITS-1:0]          an_i,
  input  logic [7:0]                   sseg_i,
  output logic [NIBBLE_W*N_DIGITS-1:0] bcd_o,
  output logic [N_DIGITS-1:0]          dp_o,
  output logic [N_DIGITS-1:0]          blank_o,
  output logic [N_DIGITS-1:0]          err_o,
  output logic                         frame_valid_o,
  output logic                         stale_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [N_DIGITS-1:0] an_r, an_last;
  logic [7:0]          sseg_r, sseg_last;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [TO_W-1:0]     tcnt;
  logic [N_DIGITS-1:0] seen;
  logic [NIBBLE_W-1:0] sh_bcd [N_DIGITS];
  logic [N_DIGITS-1:0] sh_dp, sh_blank, sh_err;
  state_t              state, state_next;
  glyph_t              glyph;
  logic                valid, changed, start, sample, complete;

  sseg_glyph_decode u_decode (
    .sseg  (sseg_r),
    .glyph (glyph)
  );

  assign valid    = $onehot(~an_r);
  assign changed  = {an_r, sseg_r} != {an_last, sseg_last};
  assign complete = &seen;
  assign stale_o  = (tcnt == TO_W'(TIMEOUT_CYCLES));

  // A fresh anode window starts from IDLE, from a change while settling, or
  // after the held digit changes; all paths share the count-of-1 load below.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start      = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE:   start = valid;
      SETTLE: begin
        if (changed) begin
          start = valid;
          if (!valid) state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (changed) begin
          start = valid;
          if (!valid) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      cnt_next   = CNT_W'(1);
      state_next = SETTLE;
    end
    if (state_next == SETTLE && cnt_next == CNT_W'(SETTLE_CYCLES)) begin
      sample     = 1'b1;
      state_next = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_r          <= '0;
      sseg_r        <= '0;
      an_last       <= '0;
      sseg_last     <= '0;
      state         <= IDLE;
      cnt           <= '0;
      tcnt          <= '0;
      seen          <= '0;
      sh_dp         <= '0;
      sh_blank      <= '0;
      sh_err        <= '0;
      bcd_o         <= '0;
      dp_o          <= '0;
      blank_o       <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      for (int unsigned k = 0; k < N_DIGITS; k++) sh_bcd[k] <= '0;
    end else begin
      an_r          <= an_i;
      sseg_r        <= sseg_i;
      an_last       <= an_r;
      sseg_last     <= sseg_r;
      state         <= state_next;
      cnt           <= cnt_next;
      frame_valid_o <= complete;
      // Completion and a new sample may coincide: the new digit opens the next frame.
      seen <= (complete ? '0 : seen) | (sample ? ~an_r : '0);
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (sample && !an_r[k]) begin
          sh_bcd[k]   <= glyph.nibble;
          sh_dp[k]    <= glyph.dp;
          sh_blank[k] <= glyph.blank;
          sh_err[k]   <= glyph.err;
        end
      end
      if (complete) begin
        for (int unsigned k = 0; k < N_DIGITS; k++) bcd_o[k*NIBBLE_W +: NIBBLE_W] <= sh_bcd[k];
        dp_o    <= sh_dp;
        blank_o <= sh_blank;
        err_o   <= sh_err;
        tcnt    <= '0;
      end else if (!stale_o) begin
        tcnt <= tcnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Randomized bench for sseg_scan_capture against a run-length based frame model.
module tb_sseg_scan_capture;

  localparam int S = 4;
  localparam int T = 50;
`ifdef SSEG_SCAN_CAPTURE_HEX_EN
  localparam int N_LEGAL = 16;
`else
  localparam int N_LEGAL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an_i = 4'hF;
  logic [7:0]  sseg_i = 8'hFF;
  logic [15:0] bcd_o;
  logic [3:0]  dp_o, blank_o, err_o;
  logic        frame_valid_o, stale_o;

  sseg_scan_capture #(.N_DIGITS(4), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .an_i(an_i), .sseg_i(sseg_i), .bcd_o(bcd_o), .dp_o(dp_o),
    .blank_o(blank_o), .err_o(err_o), .frame_valid_o(frame_valid_o), .stale_o(stale_o)
  );

  always #5 clk = ~clk;

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int          edge_no;
    logic [15:0] bcd;
    logic [3:0]  dp, bl, er;
  } frame_t;

  int tests = 0, fails = 0, cyc = 0, pulses = 0;
  int run, tout;
  bit prev_ok;
  logic [3:0]  prev_an;
  logic [7:0]  prev_seg;
  logic [3:0]  sh_nib [4];
  logic [3:0]  sh_dp, sh_bl, sh_er, seen;
  logic [15:0] e_bcd;
  logic [3:0]  e_dp, e_bl, e_er;
  logic        e_fv;
  frame_t      q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [7:0] seg);
    logic [3:0] nib = 4'h0;
    logic bl = 1'b0, er = 1'b1;
    if (seg[6:0] == 7'h7F) begin
      bl = 1'b1; er = 1'b0;
    end else begin
      for (int i = 0; i < N_LEGAL; i++)
        if (seg[6:0] == tab[i]) begin nib = 4'(i); er = 1'b0; end
    end
    return {nib, ~seg[7], bl, er};
  endfunction

  task automatic model_reset();
    run = 0; prev_ok = 0; tout = 0; seen = '0;
    sh_dp = '0; sh_bl = '0; sh_er = '0;
    for (int k = 0; k < 4; k++) sh_nib[k] = '0;
    e_bcd = '0; e_dp = '0; e_bl = '0; e_er = '0; e_fv = 1'b0;
    q.delete();
  endtask

  // Inputs present for S consecutive edges are sampled; outputs follow two edges later.
  task automatic model_edge(input logic [3:0] an, input logic [7:0] seg);
    logic [6:0] d;
    frame_t f;
    int k;
    if (prev_ok && an == prev_an && seg == prev_seg) run++; else run = 1;
    prev_ok = 1; prev_an = an; prev_seg = seg;
    if ($countones(~an) == 1 && run == S) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!an[i]) k = i;
      d = ref_decode(seg);
      sh_nib[k] = d[6:3]; sh_dp[k] = d[2]; sh_bl[k] = d[1]; sh_er[k] = d[0];
      seen[k] = 1'b1;
      if (seen == 4'hF) begin
        f.edge_no = cyc + 2;
        for (int i = 0; i < 4; i++) f.bcd[i*4 +: 4] = sh_nib[i];
        f.dp = sh_dp; f.bl = sh_bl; f.er = sh_er;
        q.push_back(f);
        seen = '0;
      end
    end
    if (q.size() > 0 && q[0].edge_no == cyc) begin
      f = q.pop_front();
      e_bcd = f.bcd; e_dp = f.dp; e_bl = f.bl; e_er = f.er;
      e_fv = 1'b1; tout = 0;
    end else begin
      e_fv = 1'b0;
      if (tout < T) tout++;
    end
  endtask

  task automatic tick(input logic [3:0] an, input logic [7:0] seg);
    an_i = an; sseg_i = seg;
    @(posedge clk);
    cyc++;
    if (rst) model_reset(); else model_edge(an, seg);
    @(negedge clk);
    if (frame_valid_o === 1'b1) pulses++;
    check("frame_valid", frame_valid_o, e_fv);
    check("stale", stale_o, tout == T);
    check("bcd", bcd_o, e_bcd);
    check("dp", dp_o, e_dp);
    check("blank", blank_o, e_bl);
    check("err", err_o, e_er);
  endtask

  task automatic hold(input int d, input logic [7:0] seg, input int len);
    for (int i = 0; i < len; i++) tick(~(4'b1 << d), seg);
  endtask

  task automatic idle(input int len);
    for (int i = 0; i < len; i++) tick(4'hF, 8'hFF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    logic [7:0] sg;
    model_reset();
    do_reset();
    check("reset_bcd", bcd_o, 16'h0);
    check("reset_flags", {dp_o, blank_o, err_o, frame_valid_o, stale_o}, 14'h0);

    // Basic 1,2,3,4 scan
    p0 = pulses;
    for (int d = 0; d < 4; d++) hold(d, {1'b1, tab[d+1]}, 10);
    idle(2);
    check("scan_pulses", pulses - p0, 1);
    check("scan_bcd", bcd_o, 16'h4321);
    check("scan_blank_err", {blank_o, err_o}, 8'h00);

    // Short window on anode 2, then full scan
    p0 = pulses;
    hold(2, {1'b1, tab[7]}, 3);
    check("short_no_pulse", pulses - p0, 0);
    hold(0, {1'b1, tab[5]}, 6); hold(1, {1'b1, tab[6]}, 6);
    hold(2, {1'b1, tab[8]}, 6); hold(3, {1'b1, tab[9]}, 6);
    idle(2);
    check("short_pulses", pulses - p0, 1);
    check("short_bcd", bcd_o, 16'h9865);

    // Blank with dp and illegal glyph
    hold(0, 8'h7F, 6); hold(1, 8'h89, 6); hold(2, 8'hC0, 6); hold(3, 8'h99, 6);
    idle(2);
    check("blank0", blank_o[0], 1'b1);
    check("dp0", dp_o[0], 1'b1);
    check("err1", err_o[1], 1'b1);
    check("nib01", bcd_o[7:0], 8'h00);
    check("nib3", bcd_o[15:12], 4'h4);

    // Two anodes low, then reset mid-frame
    for (int i = 0; i < 20; i++) tick(4'b1100, {1'b1, tab[3]});
    hold(0, {1'b1, tab[1]}, 6); hold(1, {1'b1, tab[1]}, 6);
    do_reset();
    p0 = pulses;
    hold(2, {1'b1, tab[2]}, 6); hold(3, {1'b1, tab[3]}, 6);
    hold(0, {1'b1, tab[6]}, 6); hold(1, {1'b1, tab[7]}, 6);
    idle(2);
    check("rst_pulses", pulses - p0, 1);
    check("rst_bcd", bcd_o, 16'h3276);

    // Timeout
    do_reset();
    for (int i = 1; i <= T + 10; i++) begin
      tick(4'hF, 8'hFF);
      if (i == T - 1) check("stale_before", stale_o, 1'b0);
      if (i == T)     check("stale_at", stale_o, 1'b1);
    end
    for (int d = 0; d < 4; d++) hold(d, {1'b1, tab[d]}, 6);
    idle(1);
    check("stale_cleared", stale_o, 1'b0);

    // Hex glyph on digit 3
    hold(0, 8'hC0, 6); hold(1, 8'hC0, 6); hold(2, 8'hC0, 6); hold(3, 8'h88, 6);
    idle(2);
`ifdef SSEG_SCAN_CAPTURE_HEX_EN
    check("hex_nib", bcd_o[15:12], 4'hA);
    check("hex_err", err_o[3], 1'b0);
`else
    check("hex_nib", bcd_o[15:12], 4'h0);
    check("hex_err", err_o[3], 1'b1);
`endif

    // Randomized scans
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 16)       sg = {1'($urandom_range(0, 1)), tab[r]};
      else if (r == 16) sg = {1'($urandom_range(0, 1)), 7'h7F};
      else if (r == 17) sg = {1'($urandom_range(0, 1)), 7'b1010101};
      else              sg = 8'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      else if ($urandom_range(0, 9) == 0)
        for (int i = 0; i < $urandom_range(1, 8); i++) tick(4'($urandom), sg);
      else hold($urandom_range(0, 3), sg, $urandom_range(1, 12));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Reads the multiplexed seven-segment display bus driven by the team's display path and reconstructs the shown BCD digits.
- Sampled inputs are the active-low anodes plus the 8-bit active-low segment pattern (bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a).
- Used for on-board loopback self-test and for display-path verification.
- Presents a full multi-digit frame atomically and flags illegal glyphs, blanks and a stalled scan.

Parameters:
- N_DIGITS, 4: number of multiplexed digits / anode lines.
- SETTLE_CYCLES, 4: consecutive identical-input cycles required before a digit is sampled (min 1).
- TIMEOUT_CYCLES, 1000000: cycles without a completed frame before stale_o asserts.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- an_i  input  N_DIGITS  anode enables, active-low; exactly one low = valid digit select.
- sseg_i  input  8  segment pattern, active-low, {dp,g,f,e,d,c,b,a}.
- bcd_o  output  4*N_DIGITS  decoded digits; nibble k belongs to anode k.
- dp_o  output  N_DIGITS  decimal point lit, one bit per digit.
- blank_o  output  N_DIGITS  digit showed all segments off (8'hFF or 8'h7F).
- err_o  output  N_DIGITS  digit showed an unrecognised pattern.
- frame_valid_o  output  1  one-cycle pulse when the outputs update.
- stale_o  output  1  no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset: all outputs are 0, the seen-mask is cleared, the settle and timeout counters are 0, and the FSM goes to IDLE.
- Reset mid-frame discards any partially captured digits.
- Input stage: an_i and sseg_i are registered once. All following timing is counted from the registered values.
- Glyph table (seven-segment bits, dp masked): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- All-off (1111111) = blank: nibble 0, blank bit 1.
- Any other pattern: nibble 0, err bit 1.
- dp bit = ~sseg[7].
- FSM:
  - IDLE: registered an_i is not one-hot-low → stay in IDLE. Otherwise load the settle count with 1 and go to SETTLE.
  - SETTLE: registered {an,sseg} unchanged → increment the count. Any change → restart the count at 1, or go to IDLE if an becomes invalid. When the count reaches SETTLE_CYCLES, sample the digit into the shadow register at index k, set seen[k], and go to HOLD.
  - HOLD: wait for the registered {an,sseg} to change. Then go to SETTLE with count 1 if an is valid, otherwise go to IDLE. A digit is never sampled twice within one anode window.
- Re-sampling a digit before the frame completes overwrites its shadow entry.
- Frame completion:
  - The frame completes on the cycle seen becomes all-ones, in any digit order.
  - On the next clock, bcd_o, dp_o, blank_o and err_o load from the shadow registers together.
  - frame_valid_o is high for exactly that one cycle, and seen clears.
  - Latency is 1 cycle from the final sample to the output update.
  - The outputs hold between frames.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - Clears on frame completion.
  - stale_o = (counter == TIMEOUT_CYCLES).
  - stale_o clears in the same cycle frame_valid_o pulses.
- Simultaneous events: a frame completion and a new valid anode in the same cycle are both handled; the new digit's settle starts normally.

Optional Feature:
- Macro: SSEG_SCAN_CAPTURE_HEX_EN.
- Defined: these glyphs decode to nibbles A–F without err: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Not defined: those glyphs set err and give nibble 0.
- Blank detection is unchanged either way.

Decomposition:
- Package sseg_pkg holds:
  - the glyph constants (SSEG_0..SSEG_9, SSEG_A..SSEG_F, SSEG_BLANK, active-low 7-bit);
  - the FSM state enum {IDLE, SETTLE, HOLD};
  - the nibble width constant.
- Sub-module sseg_glyph_decode: combinational, 8-bit pattern → {nibble, dp, blank, err}, one instance. It is shared with any future display checkers.

Test Plan:
- Scan digits 1,2,3,4 on an=1110/1101/1011/0111, each held 10 cycles, seg patterns per table, SETTLE=4 → one frame_valid pulse; bcd_o=16'h4321; blank_o=err_o=0.
- Hold a digit only 3 cycles (less than SETTLE) on anode 2, then a full scan → that anode's sample comes from the later window; no pulse before all four digits are sampled.
- Digit 0 shows 0x7F (blank, dp lit) and digit 1 shows 0x89 (illegal) → blank_o[0]=1, dp_o[0]=1, err_o[1]=1, both nibbles 0.
- an_i=1100 (two low) for 20 cycles → no sample and no seen change. Then assert rst mid-frame after 2 digits are seen; the next full scan gives exactly one pulse with only the post-reset data.
- Hold an_i=1111 for TIMEOUT_CYCLES (overridden to 50) → stale_o=1 at cycle 50. The next completed frame clears stale_o with the frame_valid pulse.
- HEX_EN defined: pattern 0x88 on digit 3 → nibble 4'hA, err=0. HEX_EN undefined: same pattern gives err_o[3]=1, nibble 0.
